int_controller: RTL and testbench

- Prioritising interrupt controller placed in front of the CPU program counter.
- Synchronises asynchronous interrupt lines, detects their rising edges, latches them as pending and masks them under software control.
- Presents at most one interrupt at a time to the PC through a valid/ack handshake, then blocks further interrupts until the PC signals return-from-interrupt.
- Replaces per-line edge detection inside the PC.

---
 rtl/int_controller.sv | 173 +++++++++++++++++
 tb/tb_int_controller.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/int_controller.sv
// rtl/int_controller.sv - prioritising interrupt controller with valid/ack/reti handshake
//
// Purpose: synchronises raw interrupt lines, detects rising edges, latches them
// as pending, applies a software mask and presents one interrupt at a time to
// the program counter. Further requests are blocked until return-from-interrupt.
//
// Ports:
//   clk        - system clock, rising edge
//   reset      - asynchronous active-low reset
//   int_in     - raw asynchronous interrupt lines (rising-edge triggered)
//   cfg_we     - config write strobe (single cycle)
//   cfg_addr   - config register select: 0 MASK, 1 PENDING (W1C), 2 STATUS, 3 reserved
//   cfg_wdata  - config write data
//   cfg_rdata  - config read data, combinational from cfg_addr
//   irq_valid  - interrupt request to the PC
//   irq_vector - handler address (VEC_BASE + id)
//   irq_id     - index of the requested line
//   irq_ack    - PC has taken the interrupt (only honoured while requesting)
//   reti       - return-from-interrupt pulse
//   in_service - high from ack until reti
module int_controller #(
  parameter int          NUM_INT     = 4,
  parameter logic [26:0] VEC_BASE    = 27'd1,
  parameter int          SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_INT-1:0] int_in,
  input  logic               cfg_we,
  input  logic [1:0]         cfg_addr,
  input  logic [31:0]        cfg_wdata,
  output logic [31:0]        cfg_rdata,
  output logic               irq_valid,
  output logic [26:0]        irq_vector,
  output logic [2:0]         irq_id,
  input  logic               irq_ack,
  input  logic               reti,
  output logic               in_service
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } state_t;

  state_t                               r_state;
  logic [SYNC_STAGES-1:0][NUM_INT-1:0]  r_sync;
  logic [NUM_INT-1:0]                   r_hist;
  logic [NUM_INT-1:0]                   r_pending;
  logic [NUM_INT-1:0]                   r_mask;
  logic                                 r_irq_valid;
  logic [26:0]                          r_irq_vector;
  logic [2:0]                           r_irq_id;
  logic                                 r_in_service;

  logic [NUM_INT-1:0]                   w_edge;
  logic [NUM_INT-1:0]                   w_eligible;
  logic [NUM_INT-1:0]                   w_ack_clr;
  logic [NUM_INT-1:0]                   w_w1c_clr;
  logic [2:0]                           w_sel_id;
  logic                                 w_ack;
  logic                                 w_unused;

  // Upper write-data bits carry no state.
  assign w_unused = ^cfg_wdata[31:NUM_INT];

  // Synchroniser chain followed by one history flop for edge detection.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync <= '0;
      r_hist <= '0;
    end else begin
      r_sync[0] <= int_in;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        r_sync[s] <= r_sync[s-1];
      end
      r_hist <= r_sync[SYNC_STAGES-1];
    end
  end

  assign w_edge     = r_sync[SYNC_STAGES-1] & ~r_hist;
  assign w_eligible = r_pending & r_mask;
  assign w_ack      = (r_state == REQ) && irq_ack;

  // Lowest set index wins: scan downward so the last hit is the smallest.
  always_comb begin
    w_sel_id = 3'd0;
    for (int i = NUM_INT - 1; i >= 0; i--) begin
      if (w_eligible[i]) begin
        w_sel_id = 3'(i);
      end
    end
  end

  always_comb begin
    w_ack_clr = '0;
    for (int i = 0; i < NUM_INT; i++) begin
      if (r_irq_id == 3'(i)) begin
        w_ack_clr[i] = w_ack;
      end
    end
  end

  assign w_w1c_clr = (cfg_we && cfg_addr == 2'd1) ? cfg_wdata[NUM_INT-1:0] : '0;

  // Set is OR-ed in after the clear so a coincident edge keeps the bit set.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pending <= '0;
      r_mask    <= {NUM_INT{1'b1}};
    end else begin
      r_pending <= (r_pending & ~(w_ack_clr | w_w1c_clr)) | w_edge;
      if (cfg_we && cfg_addr == 2'd0) begin
        r_mask <= cfg_wdata[NUM_INT-1:0];
      end
    end
  end

  // Request FSM; id/vector are captured in IDLE and held frozen through REQ.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= IDLE;
      r_irq_valid  <= 1'b0;
      r_irq_vector <= '0;
      r_irq_id     <= '0;
      r_in_service <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (|w_eligible) begin
            r_irq_id     <= w_sel_id;
            r_irq_vector <= VEC_BASE + 27'(w_sel_id);
            r_irq_valid  <= 1'b1;
            r_state      <= REQ;
          end
        end
        REQ: begin
          if (irq_ack) begin
            r_irq_valid  <= 1'b0;
            r_in_service <= 1'b1;
            r_state      <= SERVICE;
          end
        end
        SERVICE: begin
          if (reti) begin
            r_in_service <= 1'b0;
            r_state      <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  always_comb begin
    cfg_rdata = '0;
    case (cfg_addr)
      2'd0:    cfg_rdata = 32'(r_mask);
      2'd1:    cfg_rdata = 32'(r_pending);
      2'd2:    cfg_rdata = {25'd0, r_irq_id, 2'b00, r_in_service, r_irq_valid};
      default: cfg_rdata = '0;
    endcase
  end

  assign irq_valid  = r_irq_valid;
  assign irq_vector = r_irq_vector;
  assign irq_id     = r_irq_id;
  assign in_service = r_in_service;

endmodule

// File: tb/tb_int_controller.sv
// tb/tb_int_controller.sv - self-checking bench for int_controller
module tb_int_controller;

  logic        clk;
  logic        reset;
  logic [3:0]  int_in;
  logic        cfg_we;
  logic [1:0]  cfg_addr;
  logic [31:0] cfg_wdata;
  logic [31:0] cfg_rdata;
  logic        irq_valid;
  logic [26:0] irq_vector;
  logic [2:0]  irq_id;
  logic        irq_ack;
  logic        reti;
  logic        in_service;

  int errors;
  int checks;

  typedef struct {
    logic [2:0]  id;
    logic [26:0] vec;
  } exp_t;
  exp_t sb[$];

  int_controller #(.NUM_INT(4), .VEC_BASE(27'd1), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset(reset), .int_in(int_in),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata), .cfg_rdata(cfg_rdata),
    .irq_valid(irq_valid), .irq_vector(irq_vector), .irq_id(irq_id),
    .irq_ack(irq_ack), .reti(reti), .in_service(in_service)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    cfg_addr = a;
    #1;
    d = cfg_rdata;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
    tick();
    cfg_we = 1'b0; cfg_wdata = '0;
  endtask

  task automatic do_ack();
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
  endtask

  task automatic do_reti();
    reti = 1'b1;
    tick();
    reti = 1'b0;
  endtask

  task automatic wait_valid(input int max, output bit ok);
    for (int i = 0; i < max && !irq_valid; i++) tick();
    ok = irq_valid;
  endtask

  task automatic push_exp(input logic [2:0] id);
    exp_t e;
    e.id  = id;
    e.vec = 27'd1 + 27'(id);
    sb.push_back(e);
  endtask

  task automatic settle();
    int_in = '0;
    ticks(4);
  endtask

  task automatic test_reset();
    logic [31:0] d;
    checks++; if (irq_valid !== 1'b0)  begin errors++; $display("FAIL reset_valid got=%b exp=0", irq_valid); end
    checks++; if (irq_id !== 3'd0)     begin errors++; $display("FAIL reset_id got=%0d exp=0", irq_id); end
    checks++; if (irq_vector !== 27'd0) begin errors++; $display("FAIL reset_vec got=%0d exp=0", irq_vector); end
    checks++; if (in_service !== 1'b0) begin errors++; $display("FAIL reset_insvc got=%b exp=0", in_service); end
    rd(2'd0, d);
    checks++; if (d !== 32'hF) begin errors++; $display("FAIL reset_mask got=%h exp=f", d); end
    rd(2'd1, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL reset_pending got=%h exp=0", d); end
    rd(2'd2, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL reset_status got=%h exp=0", d); end
    wr(2'd3, 32'hFFFF_FFFF);
    rd(2'd3, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL reserved_rd got=%h exp=0", d); end
    rd(2'd0, d);
    checks++; if (d !== 32'hF) begin errors++; $display("FAIL reserved_wr_mask got=%h exp=f", d); end
  endtask

  task automatic test_single();
    logic [31:0] d;
    exp_t e;
    tick();
    int_in = 4'b0100;
    push_exp(3'd2);
    ticks(3);
    rd(2'd1, d);
    checks++; if (d !== 32'h4) begin errors++; $display("FAIL single_pending got=%h exp=4", d); end
    checks++; if (irq_valid !== 1'b0) begin errors++; $display("FAIL single_early_valid got=%b exp=0", irq_valid); end
    tick();
    checks++;
    if (irq_valid !== 1'b1 || sb.size() == 0) begin
      errors++; $display("FAIL single_valid got=%b exp=1", irq_valid);
    end else begin
      e = sb.pop_front();
      if (irq_id !== e.id || irq_vector !== e.vec) begin
        errors++; $display("FAIL single_req got id=%0d vec=%0d exp id=%0d vec=%0d", irq_id, irq_vector, e.id, e.vec);
      end
    end
    tick();
    do_ack();
    rd(2'd1, d);
    checks++;
    if (irq_valid !== 1'b0 || in_service !== 1'b1 || d !== 32'h0) begin
      errors++; $display("FAIL single_ack got valid=%b insvc=%b pend=%h exp 0/1/0", irq_valid, in_service, d);
    end
    rd(2'd2, d);
    checks++; if (d !== 32'h22) begin errors++; $display("FAIL single_status got=%h exp=22", d); end
    do_reti();
    checks++; if (in_service !== 1'b0) begin errors++; $display("FAIL single_reti got=%b exp=0", in_service); end
    settle();
  endtask

  task automatic test_priority();
    bit ok;
    exp_t e;
    int_in = 4'b1010;
    push_exp(3'd1);
    push_exp(3'd3);
    wait_valid(10, ok);
    checks++;
    if (!ok || sb.size() == 0) begin
      errors++; $display("FAIL prio_first got valid=%b exp=1", irq_valid);
    end else begin
      e = sb.pop_front();
      if (irq_id !== e.id || irq_vector !== e.vec) begin
        errors++; $display("FAIL prio_first got id=%0d vec=%0d exp id=%0d vec=%0d", irq_id, irq_vector, e.id, e.vec);
      end
    end
    do_ack();
    ticks(2);
    do_reti();
    checks++; if (irq_valid !== 1'b0) begin errors++; $display("FAIL prio_gap got=%b exp=0", irq_valid); end
    tick();
    checks++;
    if (irq_valid !== 1'b1 || sb.size() == 0) begin
      errors++; $display("FAIL prio_second got valid=%b exp=1", irq_valid);
    end else begin
      e = sb.pop_front();
      if (irq_id !== e.id || irq_vector !== e.vec) begin
        errors++; $display("FAIL prio_second got id=%0d vec=%0d exp id=%0d vec=%0d", irq_id, irq_vector, e.id, e.vec);
      end
    end
    do_ack();
    do_reti();
    settle();
  endtask

  task automatic test_mask();
    logic [31:0] d;
    exp_t e;
    wr(2'd0, 32'hE);
    int_in = 4'b0001;
    push_exp(3'd0);
    ticks(6);
    rd(2'd1, d);
    checks++; if (d !== 32'h1) begin errors++; $display("FAIL mask_pending got=%h exp=1", d); end
    checks++; if (irq_valid !== 1'b0) begin errors++; $display("FAIL mask_blocked got=%b exp=0", irq_valid); end
    wr(2'd0, 32'hF);
    checks++; if (irq_valid !== 1'b0) begin errors++; $display("FAIL mask_same_edge got=%b exp=0", irq_valid); end
    tick();
    checks++;
    if (irq_valid !== 1'b1 || sb.size() == 0) begin
      errors++; $display("FAIL mask_unmask got valid=%b exp=1", irq_valid);
    end else begin
      e = sb.pop_front();
      if (irq_id !== e.id || irq_vector !== e.vec) begin
        errors++; $display("FAIL mask_unmask got id=%0d vec=%0d exp id=%0d vec=%0d", irq_id, irq_vector, e.id, e.vec);
      end
    end
    do_ack();
    do_reti();
    settle();
  endtask

  task automatic test_blocking();
    logic [31:0] d;
    bit ok;
    exp_t e;
    int_in = 4'b0010;
    push_exp(3'd1);
    wait_valid(10, ok);
    checks++;
    if (!ok || sb.size() == 0) begin
      errors++; $display("FAIL block_first got valid=%b exp=1", irq_valid);
    end else begin
      e = sb.pop_front();
      if (irq_id !== e.id) begin errors++; $display("FAIL block_first got id=%0d exp=%0d", irq_id, e.id); end
    end
    do_ack();
    int_in = 4'b0110;
    push_exp(3'd2);
    ticks(5);
    rd(2'd1, d);
    checks++;
    if (irq_valid !== 1'b0 || d !== 32'h4) begin
      errors++; $display("FAIL block_svc got valid=%b pend=%h exp valid=0 pend=4", irq_valid, d);
    end
    do_reti();
    wait_valid(4, ok);
    checks++;
    if (!ok || sb.size() == 0) begin
      errors++; $display("FAIL block_after got valid=%b exp=1", irq_valid);
    end else begin
      e = sb.pop_front();
      if (irq_id !== e.id || irq_vector !== e.vec) begin
        errors++; $display("FAIL block_after got id=%0d vec=%0d exp id=%0d vec=%0d", irq_id, irq_vector, e.id, e.vec);
      end
    end
    do_ack();
    do_reti();
    ticks(8);
    rd(2'd1, d);
    checks++;
    if (irq_valid !== 1'b0 || d !== 32'h0) begin
      errors++; $display("FAIL block_held got valid=%b pend=%h exp valid=0 pend=0", irq_valid, d);
    end
    settle();
  endtask

  task automatic test_back_to_back();
    logic [31:0] d;
    bit ok;
    exp_t e;
    int_in = 4'b0001;
    push_exp(3'd0);
    push_exp(3'd0);
    wait_valid(10, ok);
    checks++;
    if (!ok || sb.size() == 0) begin
      errors++; $display("FAIL b2b_first got valid=%b exp=1", irq_valid);
    end else begin
      e = sb.pop_front();
      if (irq_id !== e.id) begin errors++; $display("FAIL b2b_first got id=%0d exp=%0d", irq_id, e.id); end
    end
    int_in = 4'b0000;
    ticks(3);
    int_in = 4'b0001;
    ticks(2);
    do_ack();
    rd(2'd1, d);
    checks++;
    if (in_service !== 1'b1 || d !== 32'h1) begin
      errors++; $display("FAIL b2b_ack_edge got insvc=%b pend=%h exp insvc=1 pend=1", in_service, d);
    end
    do_reti();
    wait_valid(4, ok);
    checks++;
    if (!ok || sb.size() == 0) begin
      errors++; $display("FAIL b2b_rereq got valid=%b exp=1", irq_valid);
    end else begin
      e = sb.pop_front();
      if (irq_id !== e.id || irq_vector !== e.vec) begin
        errors++; $display("FAIL b2b_rereq got id=%0d vec=%0d exp id=%0d vec=%0d", irq_id, irq_vector, e.id, e.vec);
      end
    end
    do_ack();
    do_reti();
    settle();
    wr(2'd0, 32'h7);
    int_in = 4'b1000;
    ticks(2);
    wr(2'd1, 32'h8);
    rd(2'd1, d);
    checks++; if (d !== 32'h8) begin errors++; $display("FAIL w1c_edge got=%h exp=8", d); end
    checks++; if (irq_valid !== 1'b0) begin errors++; $display("FAIL w1c_masked got=%b exp=0", irq_valid); end
    wr(2'd1, 32'h8);
    rd(2'd1, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL w1c_clear got=%h exp=0", d); end
    wr(2'd0, 32'hF);
    settle();
  endtask

  task automatic test_reset_mid_service();
    logic [31:0] d;
    bit ok;
    exp_t e;
    int_in = 4'b0001;
    push_exp(3'd0);
    wait_valid(10, ok);
    checks++;
    if (!ok || sb.size() == 0) begin
      errors++; $display("FAIL rst_req got valid=%b exp=1", irq_valid);
    end else begin
      e = sb.pop_front();
      if (irq_id !== e.id) begin errors++; $display("FAIL rst_req got id=%0d exp=%0d", irq_id, e.id); end
    end
    do_ack();
    int_in = 4'b0111;
    ticks(4);
    rd(2'd1, d);
    checks++; if (d !== 32'h6 || in_service !== 1'b1) begin errors++; $display("FAIL rst_pre got pend=%h insvc=%b exp pend=6 insvc=1", d, in_service); end
    #2;
    reset = 1'b0;
    #1;
    rd(2'd1, d);
    checks++;
    if (in_service !== 1'b0 || irq_valid !== 1'b0 || d !== 32'h0) begin
      errors++; $display("FAIL rst_async got insvc=%b valid=%b pend=%h exp 0/0/0", in_service, irq_valid, d);
    end
    int_in = 4'b0000;
    @(posedge clk);
    #1;
    reset = 1'b1;
    tick();
    rd(2'd0, d);
    checks++; if (d !== 32'hF) begin errors++; $display("FAIL rst_mask got=%h exp=f", d); end
    checks++; if (sb.size() != 0) begin errors++; $display("FAIL sb_drain got=%0d exp=0", sb.size()); end
  endtask

  initial begin
    errors = 0; checks = 0;
    reset = 1'b0; int_in = '0; cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0;
    irq_ack = 1'b0; reti = 1'b0;
    ticks(3);
    reset = 1'b1;
    tick();
    test_reset();
    test_single();
    test_priority();
    test_mask();
    test_blocking();
    test_back_to_back();
    test_reset_mid_service();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
